// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one Avalon-style memory port between instruction
// fetch (read only) and the data stage (load, store, cx exchange).
// Only one access is in flight at a time. A cx runs its read and its write
// back to back, with no fetch between them. When both requesters are
// eligible in the same cycle, the grant alternates between them.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic                  fetch_done,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  data_req,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic                  data_done,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_wait,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_read_valid
);

    typedef enum logic [2:0] {
        IDLE,
        F_CMD,
        F_DATA,
        D_RCMD,
        D_RDATA,
        D_WCMD
    } state_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_t;

    state_t                state_reg;
    grant_t                last_grant_reg;
    logic                  is_cx_reg;
    logic                  fetch_done_reg;
    logic                  data_done_reg;
    logic [DATA_WIDTH-1:0] fetch_data_reg;
    logic [DATA_WIDTH-1:0] data_read_data_reg;

    logic                  fetch_eligible;
    logic                  data_eligible;
    logic                  grant_fetch;
    logic                  grant_data;

    assign fetch_done     = fetch_done_reg;
    assign fetch_data     = fetch_data_reg;
    assign data_done      = data_done_reg;
    assign data_read_data = data_read_data_reg;

    // Eligibility and grant. A requester whose done pulse is high this cycle
    // still has req high, so the pulse masks it. Ties go to the requester
    // that was not granted last.
    always_comb begin
        fetch_eligible = fetch_req && !fetch_done_reg;
        data_eligible  = data_req && !data_done_reg;
        grant_data     = data_eligible &&
                         (!fetch_eligible || (last_grant_reg == GRANT_FETCH));
        grant_fetch    = fetch_eligible && !grant_data;
    end

    // Memory command outputs decode directly from the state. This makes them
    // drop as soon as reset is asserted, and holds them steady while
    // mem_wait is high.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state_reg)
            F_CMD: begin
                mem_read    = 1'b1;
                mem_address = fetch_address;
            end
            D_RCMD: begin
                mem_read    = 1'b1;
                mem_address = data_address;
            end
            D_WCMD: begin
                mem_write      = 1'b1;
                mem_address    = data_address;
                mem_write_data = data_write_data;
            end
            default: ;
        endcase
    end

    // Sequencer: handles arbitration, command/response tracking, and the
    // registered done pulses and read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            last_grant_reg     <= GRANT_DATA;
            is_cx_reg          <= 1'b0;
            fetch_done_reg     <= 1'b0;
            data_done_reg      <= 1'b0;
            fetch_data_reg     <= '0;
            data_read_data_reg <= '0;
        end else begin
            fetch_done_reg <= 1'b0;
            data_done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_data) begin
                        last_grant_reg <= GRANT_DATA;
                        // Record the operation type at grant, so a cx
                        // finishes as a cx even if the flags drop.
                        is_cx_reg      <= data_read && data_write;
                        if (data_read) begin
                            state_reg <= D_RCMD;
                        end else if (data_write) begin
                            state_reg <= D_WCMD;
                        end else begin
                            // No memory work is needed; acknowledge at once.
                            data_done_reg <= 1'b1;
                        end
                    end else if (grant_fetch) begin
                        last_grant_reg <= GRANT_FETCH;
                        state_reg      <= F_CMD;
                    end
                end
                F_CMD: begin
                    if (!mem_wait) begin
                        state_reg <= F_DATA;
                    end
                end
                F_DATA: begin
                    if (mem_read_valid) begin
                        fetch_data_reg <= mem_read_data;
                        fetch_done_reg <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                D_RCMD: begin
                    if (!mem_wait) begin
                        state_reg <= D_RDATA;
                    end
                end
                D_RDATA: begin
                    if (mem_read_valid) begin
                        data_read_data_reg <= mem_read_data;
                        if (is_cx_reg) begin
                            // Move straight to the write half; IDLE is
                            // skipped, so fetch cannot be granted here.
                            state_reg <= D_WCMD;
                        end else begin
                            data_done_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                end
                D_WCMD: begin
                    if (!mem_wait) begin
                        data_done_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized test of memory_arbiter.
// The bench contains a behavioural memory slave with random wait states,
// random read-valid delays and stray valid pulses. Results are compared
// against a transaction-level reference memory.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          fetch_req;
    logic [AW-1:0] fetch_address;
    logic          fetch_done;
    logic [DW-1:0] fetch_data;
    logic          data_req;
    logic          data_read;
    logic          data_write;
    logic [AW-1:0] data_address;
    logic [DW-1:0] data_write_data;
    logic          data_done;
    logic [DW-1:0] data_read_data;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_write_data;
    logic          mem_wait;
    logic [DW-1:0] mem_read_data;
    logic          mem_read_valid;

    memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_req       (fetch_req),
        .fetch_address   (fetch_address),
        .fetch_done      (fetch_done),
        .fetch_data      (fetch_data),
        .data_req        (data_req),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_write_data (data_write_data),
        .data_done       (data_done),
        .data_read_data  (data_read_data),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_write_data  (mem_write_data),
        .mem_wait        (mem_wait),
        .mem_read_data   (mem_read_data),
        .mem_read_valid  (mem_read_valid)
    );

    always #5 clock = ~clock;

    // Checking ------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    endtask

    // Memories: slave storage and reference model -------------------------
    // Fetch uses word indices 64..127 and data uses 0..63, so the reference
    // does not depend on how fetch and data interleave.
    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = 32'(i);
        if (i == 64) return 32'hDEADBEEF;
        if (i == 8)  return 32'd5;
        return 32'h3C00_0000 ^ (w * 32'h0101_0111);
    endfunction

    // Slave knobs (written by the main process only)
    int wait_fixed = 0;     // >= 0: exact wait cycles per command; -1: random
    int wait_pct   = 0;
    int vdelay_min = 0;
    int vdelay_max = 0;
    bit stray_en   = 1'b0;

    // Slave state and protocol-violation counters
    bit          rd_pending    = 1'b0;
    int          rd_delay      = 0;
    logic [31:0] rd_value      = '0;
    bit          cmd_waiting   = 1'b0;
    int          wait_left     = 0;
    bit          h_rd          = 1'b0;
    bit          h_wr          = 1'b0;
    logic [31:0] h_addr        = '0;
    logic [31:0] h_wd          = '0;
    bit          cx_wait_write = 1'b0;
    logic [31:0] cx_addr       = '0;
    int          rw_viol       = 0;
    int          hold_viol     = 0;
    int          atom_viol     = 0;

    // Memory slave: acts on the falling edge, while DUT outputs are stable.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = init_word(i);
        mem_wait       = 1'b0;
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                cmd_waiting   = 1'b0;
                wait_left     = 0;
                cx_wait_write = 1'b0;
            end
            if (rd_pending) begin
                if (rd_delay == 0) begin
                    mem_read_valid = 1'b1;
                    mem_read_data  = rd_value;
                    rd_pending     = 1'b0;
                end else begin
                    mem_read_valid = 1'b0;
                    mem_read_data  = $urandom;
                    rd_delay--;
                end
            end else if (stray_en && ($urandom_range(3, 0) == 0)) begin
                mem_read_valid = 1'b1;
                mem_read_data  = $urandom;
            end else begin
                mem_read_valid = 1'b0;
                mem_read_data  = $urandom;
            end
            if (mem_read || mem_write) begin
                if (mem_read && mem_write) rw_viol++;
                if (cmd_waiting) begin
                    if (mem_read !== h_rd || mem_write !== h_wr ||
                        mem_address !== h_addr || mem_write_data !== h_wd)
                        hold_viol++;
                end else begin
                    if (wait_fixed >= 0) wait_left = wait_fixed;
                    else if ($urandom_range(99, 0) < wait_pct)
                        wait_left = int'($urandom_range(3, 1));
                    else wait_left = 0;
                    h_rd   = mem_read;
                    h_wr   = mem_write;
                    h_addr = mem_address;
                    h_wd   = mem_write_data;
                end
                if (wait_left > 0) begin
                    mem_wait    = 1'b1;
                    cmd_waiting = 1'b1;
                    wait_left--;
                end else begin
                    mem_wait    = 1'b0;
                    cmd_waiting = 1'b0;
                    if (cx_wait_write) begin
                        if (!(mem_write && mem_address == cx_addr)) atom_viol++;
                        cx_wait_write = 1'b0;
                    end
                    if (mem_read) begin
                        rd_pending = 1'b1;
                        rd_value   = mem[mem_address[8:2]];
                        rd_delay   = int'($urandom_range(vdelay_max, vdelay_min));
                        if (!mem_address[8] && data_write) begin
                            cx_wait_write = 1'b1;
                            cx_addr       = mem_address;
                        end
                    end else begin
                        mem[mem_address[8:2]] = mem_write_data;
                    end
                end
            end else begin
                if (cmd_waiting) hold_viol++;
                cmd_waiting = 1'b0;
                mem_wait    = 1'($urandom_range(1, 0));
            end
        end
    end

    // Cycle monitors: count done pulses and command-active cycles
    int n_fetch_done = 0;
    int n_data_done  = 0;
    int n_rd_cycles  = 0;
    int n_wr_cycles  = 0;
    always @(negedge clock) begin
        if (fetch_done) n_fetch_done <= n_fetch_done + 1;
        if (data_done)  n_data_done  <= n_data_done + 1;
        if (mem_read)   n_rd_cycles  <= n_rd_cycles + 1;
        if (mem_write)  n_wr_cycles  <= n_wr_cycles + 1;
    end

    // Transaction-level model state
    bit          done_order[$];   // 0 = fetch served, 1 = data served
    bit          model_last  = 1'b1;
    logic [31:0] model_drd   = '0;
    int          n_fetch_txn = 0;
    int          n_data_txn  = 0;

    task automatic step_cycles(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input bit drop_early,
                            output int lat);
        logic [31:0] expv;
        bit          seen;
        int          n;
        expv          = ref_mem[addr[8:2]];
        fetch_address = addr;
        fetch_req     = 1'b1;
        seen          = 1'b0;
        n             = 0;
        while (!seen && n < 300) begin
            @(posedge clock);
            #1;
            n++;
            if (fetch_done) seen = 1'b1;
            else if (drop_early && n == 1) fetch_req = 1'b0;
        end
        fetch_req = 1'b0;
        lat       = n;
        check_value("fetch_done_seen", 32'(seen), 32'd1);
        check_value("fetch_data", fetch_data, expv);
        n_fetch_txn++;
        done_order.push_back(1'b0);
        model_last = 1'b0;
        $display("fetch addr=0x%08h data=0x%08h lat=%0d", addr, fetch_data, lat);
    endtask

    task automatic do_data(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat);
        logic [31:0] expv;
        bit          seen;
        int          n;
        string       kind;
        kind = rd ? (wr ? "cx" : "ld") : (wr ? "st" : "nop");
        expv = rd ? ref_mem[addr[8:2]] : model_drd;
        if (wr) ref_mem[addr[8:2]] = wd;
        model_drd       = expv;
        data_address    = addr;
        data_read       = rd;
        data_write      = wr;
        data_write_data = wd;
        data_req        = 1'b1;
        seen            = 1'b0;
        n               = 0;
        while (!seen && n < 300) begin
            @(posedge clock);
            #1;
            n++;
            if (data_done) seen = 1'b1;
        end
        data_req = 1'b0;
        lat      = n;
        check_value({kind, "_done_seen"}, 32'(seen), 32'd1);
        check_value({kind, "_read_data"}, data_read_data, expv);
        n_data_txn++;
        done_order.push_back(1'b1);
        model_last = 1'b1;
        $display("data %s addr=0x%08h wdata=0x%08h rdata=0x%08h lat=%0d",
                 kind, addr, wd, data_read_data, lat);
    endtask

    task automatic random_data(output int lat);
        int          op;
        logic [31:0] a;
        op = int'($urandom_range(3, 0));
        a  = 32'($urandom_range(63, 0)) << 2;
        case (op)
            0:       do_data(1'b1, 1'b0, a, 32'h0, lat);
            1:       do_data(1'b0, 1'b1, a, $urandom, lat);
            2:       do_data(1'b1, 1'b1, a, $urandom, lat);
            default: do_data(1'b0, 1'b0, a, $urandom, lat);
        endcase
    endtask

    // Watchdog so the run always ends on its own
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int          lat;
        int          lat_a;
        int          lat_b;
        int          r0;
        int          w0;
        int          d0;
        int          f0;
        int          bad;
        bit          exp_first;
        bit          prev;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        fetch_req       = 1'b0;
        fetch_address   = '0;
        data_req        = 1'b0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = '0;
        data_write_data = '0;
        reset_n         = 1'b1;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check_value("reset_ctl", {28'b0, fetch_done, data_done, mem_read, mem_write}, 32'd0);
        check_value("reset_data", fetch_data | data_read_data | mem_address | mem_write_data, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        step_cycles(1);

        // Tie right after reset: fetch first, then data
        done_order.delete();
        fork
            do_fetch(32'h104, 1'b0, lat_a);
            do_data(1'b1, 1'b0, 32'h24, 32'h0, lat_b);
        join
        check_value("tie1_first_is_fetch", 32'(done_order[0]), 32'd0);
        check_value("tie1_second_is_data", 32'(done_order[1]), 32'd1);

        // Second tie: the winner is the one not served last
        exp_first = ~model_last;
        done_order.delete();
        fork
            do_fetch(32'h114, 1'b0, lat_a);
            do_data(1'b1, 1'b0, 32'h30, 32'h0, lat_b);
        join
        check_value("tie2_first", 32'(done_order[0]), 32'(exp_first));

        // Fetch only, zero wait
        r0 = n_rd_cycles;
        do_fetch(32'h100, 1'b0, lat);
        step_cycles(1);
        check_value("fetch_only_lat", lat, 32'd3);
        check_value("fetch_only_data", fetch_data, 32'hDEADBEEF);
        check_value("fetch_only_rd_cycles", n_rd_cycles - r0, 32'd1);

        // Fetch whose req drops mid-transaction still completes
        do_fetch(32'h108, 1'b1, lat);
        check_value("fetch_drop_lat", lat, 32'd3);

        // cx with fetch requesting throughout; data wins the tie (fetch was last)
        exp_first = ~model_last;
        done_order.delete();
        fork
            do_data(1'b1, 1'b1, 32'h20, 32'd9, lat_a);
            do_fetch(32'h10C, 1'b0, lat_b);
        join
        check_value("cx_first_is_data", 32'(done_order[0]), 32'(exp_first));
        check_value("cx_lat", lat_a, 32'd4);
        check_value("cx_old_value", data_read_data, 32'd5);
        check_value("cx_mem_new", mem[8], 32'd9);
        check_value("cx_atomic", atom_viol, 32'd0);

        // Store with three wait cycles
        wait_fixed = 3;
        w0 = n_wr_cycles;
        d0 = n_data_done;
        do_data(1'b0, 1'b1, 32'h28, 32'hCAFE0028, lat);
        step_cycles(2);
        wait_fixed = 0;
        check_value("store_wait_lat", lat, 32'd5);
        check_value("store_wr_cycles", n_wr_cycles - w0, 32'd4);
        check_value("store_done_once", n_data_done - d0, 32'd1);
        check_value("store_hold", hold_viol, 32'd0);

        // Data access with neither flag set
        r0 = n_rd_cycles;
        w0 = n_wr_cycles;
        do_data(1'b0, 1'b0, 32'h2C, 32'h1234, lat);
        step_cycles(1);
        check_value("nop_lat", lat, 32'd1);
        check_value("nop_no_mem_cmds", (n_rd_cycles - r0) + (n_wr_cycles - w0), 32'd0);

        // Reset during F_DATA; the late read-valid must be ignored
        vdelay_min    = 5;
        vdelay_max    = 5;
        fetch_address = 32'h118;
        fetch_req     = 1'b1;
        step_cycles(2);
        #2 reset_n = 1'b0;
        #1;
        check_value("rst_mid_ctl", {28'b0, fetch_done, data_done, mem_read, mem_write}, 32'd0);
        check_value("rst_mid_data", fetch_data | data_read_data | mem_address | mem_write_data, 32'd0);
        fetch_req = 1'b0;
        f0 = n_fetch_done;
        @(posedge clock);
        #1 reset_n = 1'b1;
        model_last = 1'b1;
        model_drd  = '0;
        step_cycles(8);
        check_value("rst_no_fetch_done", n_fetch_done - f0, 32'd0);
        check_value("rst_late_valid_ignored", fetch_data, 32'd0);
        vdelay_min = 0;
        vdelay_max = 0;
        do_fetch(32'h11C, 1'b0, lat);
        check_value("post_reset_fetch_lat", lat, 32'd3);

        // Saturated: both requesters always pending, so service must alternate
        wait_fixed = -1;
        wait_pct   = 30;
        vdelay_max = 3;
        stray_en   = 1'b1;
        prev = model_last;
        done_order.delete();
        fork
            for (int i = 0; i < 10; i++)
                do_fetch(32'h100 + (32'($urandom_range(63, 0)) << 2), 1'b0, lat_a);
            for (int i = 0; i < 10; i++) random_data(lat_b);
        join
        bad = 0;
        foreach (done_order[i]) begin
            if (done_order[i] == prev) bad++;
            prev = done_order[i];
        end
        check_value("saturated_alternation", bad, 32'd0);

        // Random traffic with idle gaps
        fork
            for (int i = 0; i < 40; i++) begin
                step_cycles(int'($urandom_range(3, 0)));
                do_fetch(32'h100 + (32'($urandom_range(63, 0)) << 2), 1'b0, lat_a);
            end
            for (int i = 0; i < 40; i++) begin
                step_cycles(int'($urandom_range(3, 0)));
                random_data(lat_b);
            end
        join
        step_cycles(2);

        // Whole-run checks
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_value("final_memory_words_wrong", bad, 32'd0);
        check_value("rw_never_both", rw_viol, 32'd0);
        check_value("cmd_hold_while_wait", hold_viol, 32'd0);
        check_value("cx_atomic_all", atom_viol, 32'd0);
        check_value("fetch_done_pulse_count", n_fetch_done, n_fetch_txn);
        check_value("data_done_pulse_count", n_data_done, n_data_txn);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
